// File: rtl/ibuf2mac_pkg.sv
// ibuf2mac_pkg: shared constants for the ibuf -> MAC Tx path.
// The Rx writer packs ibuf words with the same field offsets.
package ibuf2mac_pkg;

   // ibuf word = {tdat[63:0], tkep[7:1], tlst}
   localparam int IBUF_DW  = 72;
   localparam int TDAT_LSB = 8;
   localparam int TKEP_LSB = 1;
   localparam int TLST_BIT = 0;

   // Two RAM pipeline stages (address register, RAM output register) sit in
   // front of the skid, so one word per clock needs three words of credit.
   // All three are reserved in the skid so nothing is lost under backpressure.
   localparam int SKID_DEPTH = 3;
   localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

   // s0: init, s1: idle between frames, s2: inside a frame
   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2
   } state_t;

endpackage

// File: rtl/ibuf2mac_skid.sv
// ibuf2mac_skid: small circular FIFO; its head is presented directly as the
// AXI-Stream beat. Caller guarantees no push when full and no pop when empty.
module ibuf2mac_skid
   import ibuf2mac_pkg::*;
#(
   parameter int  DW    = IBUF_DW,
   parameter int  DEPTH = 2,
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head_data,
   output logic          head_vld,
   output logic [CW-1:0] occ
);

   logic [DW-1:0] mem [DEPTH];
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] rd_idx;
   logic [CW-1:0] count;

   function automatic logic [IW-1:0] bump(input logic [IW-1:0] idx);
      return (idx == IW'(DEPTH - 1)) ? '0 : idx + 1'b1;
   endfunction

   // Index and occupancy bookkeeping; push and pop may coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
      end else begin
         if (push) wr_idx <= bump(wr_idx);
         if (pop)  rd_idx <= bump(rd_idx);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Word storage; contents are meaningless while the slot is unoccupied.
   always_ff @(posedge clk) begin
      if (push) mem[wr_idx] <= push_data;
   end

   assign head_data = mem[rd_idx];
   assign head_vld  = (count != '0);
   assign occ       = count;

endmodule

// File: rtl/ibuf2mac.sv
// ibuf2mac: drains committed ibuf frames to the MAC Tx AXI-Stream port and
// hands space back to the Rx writer through committed_cons.
// Optional feature macro: IBUF2MAC_STATS_EN adds the sent_pkts counter.
// AXIS handshake: a beat transfers on a clock edge where tval && trdy; while
// tval && !trdy the beat (tdat/tkep/tlst) is held unchanged, and tval is never
// withdrawn until the beat is taken.
module ibuf2mac
   import ibuf2mac_pkg::*;
#(
   parameter int AW = 10,
   parameter int DW = IBUF_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   input  logic [AW:0]   committed_prod,
   output logic [AW:0]   committed_cons,
   output logic [63:0]   tdat,
   output logic [7:0]    tkep,
   output logic          tval,
   output logic          tlst,
   input  logic          trdy,
`ifdef IBUF2MAC_STATS_EN
   output logic [15:0]   sent_pkts,
`endif
   output logic [1:0]    fsm_state
);

   logic [AW:0]      rd_ptr;
   logic [AW:0]      cons_ptr;
   logic             rd_v1;      // address on rd_addr this cycle
   logic             rd_v2;      // matching word on rd_data this cycle
   logic             pop;
   logic             issue;
   logic [OCC_W-1:0] occ;
   logic [2:0]       used;
   logic [DW-1:0]    head;
   logic             head_vld;
   logic             commit;
   state_t           state;
   state_t           next_state;

   assign pop  = tval && trdy;
   // Words held or on their way, counting this cycle's pop as already gone.
   assign used  = 3'(occ) + 3'(rd_v1) + 3'(rd_v2) - 3'(pop);
   assign issue = (rd_ptr != committed_prod) && (used < 3'(SKID_DEPTH));

   // Read engine: advance through committed words, running ahead across frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         rd_addr <= '0;
      end else if (issue) begin
         rd_ptr  <= rd_ptr + 1'b1;
         rd_addr <= rd_ptr[AW-1:0];
      end
   end

   // Track each read through the address and RAM output stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_v1 <= 1'b0;
         rd_v2 <= 1'b0;
      end else begin
         rd_v1 <= issue;
         rd_v2 <= rd_v1;
      end
   end

   ibuf2mac_skid #(
      .DW    (DW),
      .DEPTH (SKID_DEPTH)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rd_v2),
      .push_data (rd_data),
      .pop       (pop),
      .head_data (head),
      .head_vld  (head_vld),
      .occ       (occ)
   );

   assign tval = head_vld;
   assign tdat = head[TDAT_LSB +: 64];
   assign tkep = {head[TKEP_LSB +: 7], 1'b1};
   assign tlst = head[TLST_BIT];

   // Frame-state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S0;
      else        state <= next_state;
   end

   // Frame-state transitions; commit marks the accepted tlst beat.
   always_comb begin
      next_state = state;
      commit     = 1'b0;
      case (state)
         S0: next_state = S1;
         S1: begin
            if (pop) begin
               if (tlst) commit     = 1'b1;
               else      next_state = S2;
            end
         end
         S2: begin
            if (pop && tlst) begin
               commit     = 1'b1;
               next_state = S1;
            end
         end
         default: next_state = S0;
      endcase
   end

   assign fsm_state = state;

   // cons_ptr follows every accepted beat; committed_cons only jumps at frame ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cons_ptr       <= '0;
         committed_cons <= '0;
      end else begin
         if (pop)    cons_ptr       <= cons_ptr + 1'b1;
         if (commit) committed_cons <= cons_ptr + 1'b1;
      end
   end

`ifdef IBUF2MAC_STATS_EN
   // Frames fully accepted by the MAC, updated alongside committed_cons.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      sent_pkts <= '0;
      else if (commit) sent_pkts <= sent_pkts + 1'b1;
   end
`endif

endmodule

// File: tb/tb_ibuf2mac.sv
// tb_ibuf2mac: directed bench for ibuf2mac with a 16-entry ibuf (AW=4).
// Build with IBUF2MAC_STATS_EN defined to also cover sent_pkts.
module tb_ibuf2mac;

   localparam int AW = 4;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] rd_addr;
   logic [71:0]   rd_data;
   logic [AW:0]   committed_prod;
   logic [AW:0]   committed_cons;
   logic [63:0]   tdat;
   logic [7:0]    tkep;
   logic          tval;
   logic          tlst;
   logic          trdy;
   logic [1:0]    fsm_state;
`ifdef IBUF2MAC_STATS_EN
   logic [15:0]   sent_pkts;
`endif

   int checks = 0;
   int errors = 0;

   // ---------------- clock / reset / ibuf model ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [71:0] mem [16];
   always @(posedge clk) rd_data <= mem[rd_addr];

   ibuf2mac #(.AW(AW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .committed_prod (committed_prod),
      .committed_cons (committed_cons),
      .tdat           (tdat),
      .tkep           (tkep),
      .tval           (tval),
      .tlst           (tlst),
      .trdy           (trdy),
`ifdef IBUF2MAC_STATS_EN
      .sent_pkts      (sent_pkts),
`endif
      .fsm_state      (fsm_state)
   );

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [71:0] mk_word(input int f, input int i, input bit last);
      logic [63:0] d;
      logic [6:0]  k;
      d = {8'(f), 8'(i), 48'h0123_4567_89AB};
      k = (last && i > 0) ? 7'b0000111 : 7'h7F;
      return {d, k, last};
   endfunction

   logic [71:0] exp_q [$];

   task automatic load_frame(input int start, input int len, input int f);
      logic [71:0] w;
      for (int i = 0; i < len; i++) begin
         w = mk_word(f, i, i == len - 1);
         mem[(start + i) % 16] = w;
         exp_q.push_back(w);
      end
   endtask

   task automatic reset_dut();
      rst_n          = 1'b0;
      committed_prod = '0;
      trdy           = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   // ---------------- scoreboard / monitor ----------------
   int          beats;
   logic [AW:0] beat_ptr;
   logic [AW:0] cons_model;
   logic [AW:0] pend_cons;
   bit          pend;
   bit          in_frame;
   int          pkt_model;
   bit          held_vld;
   logic [63:0] held_dat;
   logic [7:0]  held_kep;
   logic        held_lst;

   always @(negedge clk) begin
      logic [71:0] w;
      if (!rst_n) begin
         exp_q.delete();
         beats      = 0;
         beat_ptr   = '0;
         cons_model = '0;
         pend       = 1'b0;
         in_frame   = 1'b0;
         pkt_model  = 0;
         held_vld   = 1'b0;
      end else begin
         if (held_vld) begin
            check("hold_val", tval, 1'b1);
            check("hold_dat", tdat, held_dat);
            check("hold_kep", tkep, held_kep);
            check("hold_lst", tlst, held_lst);
         end
         if (in_frame) check("no_gap", tval, 1'b1);
         if (pend) begin
            cons_model = pend_cons;
            pkt_model++;
            pend = 1'b0;
         end
         check("cons", committed_cons, cons_model);
`ifdef IBUF2MAC_STATS_EN
         check("sent_pkts", sent_pkts, 16'(pkt_model));
`endif
         if (tval && trdy) begin
            check("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               w = exp_q.pop_front();
               check("tdat", tdat, w[71:8]);
               check("tkep", tkep, {w[7:1], 1'b1});
               check("tlst", tlst, w[0]);
            end
            beats++;
            beat_ptr = beat_ptr + 1'b1;
            if (tlst) begin
               pend      = 1'b1;
               pend_cons = beat_ptr;
               in_frame  = 1'b0;
            end else begin
               in_frame = 1'b1;
            end
         end
         held_vld = tval && !trdy;
         held_dat = tdat;
         held_kep = tkep;
         held_lst = tlst;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      rst_n          = 1'b0;
      committed_prod = '0;
      trdy           = 1'b1;
      #12;
      check("rst_tval", tval, 1'b0);
      check("rst_cons", committed_cons, 0);
      check("rst_addr", rd_addr, 0);
      check("rst_state", fsm_state, 2'd0);
      reset_dut();
      check("init_state", fsm_state, 2'd1);

      // 1-word frame: tval exactly three clocks after committed_prod moves
      load_frame(0, 1, 1);
      committed_prod = 5'd1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("lat_tval_lo", tval, 1'b0);
      end
      @(negedge clk);
      check("lat_tval_hi", tval, 1'b1);
      check("lat_tkep", tkep, 8'hFF);
      check("lat_tlst", tlst, 1'b1);
      @(negedge clk);
      check("lat_cons", committed_cons, 1);
      check("lat_state", fsm_state, 2'd1);

      // two back-to-back 8-word frames, no bubbles
      reset_dut();
      load_frame(0, 8, 2);
      load_frame(8, 8, 3);
      committed_prod = 5'd16;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (tval) break;
      end
      for (int b = 0; b < 16; b++) begin
         if (b > 0) @(negedge clk);
         check("b2b_tval", tval, 1'b1);
         if (b == 8) check("b2b_cons8", committed_cons, 8);
      end
      @(negedge clk);
      check("b2b_cons16", committed_cons, 16);
      check("b2b_beats", beats, 16);

      // trdy toggling 1010...
      reset_dut();
      load_frame(0, 8, 4);
      committed_prod = 5'd8;
      for (int n = 0; n < 60 && committed_cons != 5'd8; n++) begin
         tick();
         trdy = ~trdy;
      end
      trdy = 1'b1;
      check("stall_cons", committed_cons, 8);
      check("stall_beats", beats, 8);

      // three 7-word frames crossing the 15 -> 0 address wrap
      reset_dut();
      load_frame(0, 7, 5);
      load_frame(7, 7, 6);
      committed_prod = 5'd14;
      for (int n = 0; n < 60 && committed_cons != 5'd7; n++) tick();
      check("wrap_cons7", committed_cons, 7);
      load_frame(14, 7, 7);
      committed_prod = 5'd21;
      for (int n = 0; n < 80 && committed_cons != 5'd21; n++) tick();
      check("wrap_cons21", committed_cons, 21);
      check("wrap_beats", beats, 21);

      // reset in the middle of an 8-word frame, while beat 3 is presented
      reset_dut();
      load_frame(0, 8, 8);
      committed_prod = 5'd8;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         #1;
         if (beats >= 3) break;
      end
      check("mid_beats", beats, 3);
      rst_n = 1'b0;
      #1;
      check("mid_tval", tval, 1'b0);
      check("mid_cons", committed_cons, 0);
      check("mid_state", fsm_state, 2'd0);
      committed_prod = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("idle_tval", tval, 1'b0);
         check("idle_addr", rd_addr, 0);
      end

      // five frames, including back-to-back 1-word frames
      tick();
      load_frame(0, 1, 9);
      load_frame(1, 1, 10);
      load_frame(2, 3, 11);
      load_frame(5, 2, 12);
      load_frame(7, 4, 13);
      committed_prod = 5'd11;
      for (int n = 0; n < 60 && committed_cons != 5'd11; n++) tick();
      check("five_cons", committed_cons, 11);
      check("five_beats", beats, 11);
      @(negedge clk);
`ifdef IBUF2MAC_STATS_EN
      check("five_pkts", sent_pkts, 5);
`endif
      check("five_state", fsm_state, 2'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
